apb_fabric_intc: RTL and testbench
==================================

# apb_fabric_intc

APB interconnect and interrupt controller between the CPU's APB master port and the SoC peripherals. Decodes each CPU transfer to one of four external slaves (system ROM, SRAM, UART, timer) or the internal interrupt-controller register bank, and returns the selected slave's read data, ready and error. The internal interrupt controller combines the timer interrupt and bus-error events into the single CPU interrupt line.

## Interface
- ADDR_WIDTH, 32, APB address width
- DATA_WIDTH, 32, APB data width
- clk  in  1  system clock, all state on rising edge
- rts  in  1  reset, asynchronous, active-high
- m_paddr  in  ADDR_WIDTH  master address
- m_pwdata  in  DATA_WIDTH  master write data (also routed to all slaves)
- m_prdata  out  DATA_WIDTH  read data to master
- m_psel / m_penable / m_pwrite  in  1  master APB controls
- m_pstb  in  4  byte strobes, bit n enables byte n
- m_pready / m_perr  out  1  transfer complete / transfer error
- {sys,sram,uart,timer}_sel  out  1  per-slave select
- {sys,sram,uart,timer}_enable  out  1  per-slave access-phase enable
- {sys,sram,uart,timer}_rdata  in  DATA_WIDTH  per-slave read data
- {sys,sram,uart,timer}_ready / _perr  in  1  per-slave ready / error
- timer_irq  in  1  level interrupt from timer
- cpu_irq  out  1  interrupt request to CPU

## Operation
- Address map (inclusive): SYS 0x0000_0000–0x0000_FFFF; UART 0x1000_0000–0x1000_0FFF; INTC 0x1000_1000–0x1000_1FFF; TIMER 0x1000_2000–0x1000_2FFF; SRAM 0x8000_0000–0x8FFF_FFFF; all else unmapped.
- Decode is combinational from m_paddr. x_sel = m_psel & hit_x; x_enable = m_penable & m_psel & hit_x. Exactly one target is hit or none.
- Return mux: m_prdata/m_pready/m_perr come from the hit slave. No m_psel: m_pready=0, m_perr=0, m_prdata=0.
- Unmapped: m_prdata=0; in access phase (m_psel & m_penable) m_pready=1, m_perr=1; in setup phase both 0.
- INTC registers (offset m_paddr[11:0]), zero wait state, m_pready=1 in access phase, m_perr=0:
  - 0x000 PENDING: bit0 = timer_irq (live level), bit1 = BUSERR latch; read-only except write 1 to bit1 with m_pstb[0] clears it.
  - 0x004 ENABLE: bits[1:0] RW (needs m_pstb[0]); bits[31:2] read 0.
  - 0x008 ACTIVE: PENDING & ENABLE, read-only.
  - Other offsets: read 0, writes ignored.
- Writes commit on the clock edge where m_psel & m_penable & m_pwrite & INTC hit.
- BUSERR latch sets on any clock where m_psel & m_penable & m_pready & m_perr (any target, including unmapped). Set wins over simultaneous clear.
- cpu_irq register <= |(PENDING & ENABLE).

## Timing
- Reset (rts=1, any time, asynchronous): ENABLE=0, BUSERR=0, cpu_irq=0. Decode outputs remain combinational and unaffected. A transfer in flight during reset is abandoned; the master restarts with a setup phase.
- Decode/return path: 0 cycles (combinational). External slave wait states pass straight through via x_ready.
- INTC access: setup cycle + one access cycle; read data valid in the access cycle.
- cpu_irq: asserts/deasserts one clock after the cause (timer_irq change, ENABLE write, BUSERR set/clear) becomes visible at the clock edge.
- Back-to-back transfers to different targets need no idle cycle; sel follows m_paddr each cycle.

## Test plan
- Reset: assert rts mid-transfer -> cpu_irq=0, read of INTC 0x004 returns 0x0, 0x000 returns 0x0 with timer_irq=0.
- Decode: read 0x8000_0010 with sram_rdata=0xDEADBEEF, sram_ready low 2 cycles -> only sram_sel/enable high, m_pready waits 2 cycles, m_prdata=0xDEADBEEF; repeat for 0x0000_0004, 0x1000_0000, 0x1000_2000.
- Unmapped read 0x2000_0000 -> access phase m_pready=1, m_perr=1, m_prdata=0; next read of INTC 0x000 returns 0x2.
- Interrupt: write ENABLE=0x1, raise timer_irq -> cpu_irq=1 one clock later; ACTIVE reads 0x1; drop timer_irq -> cpu_irq=0 one clock later.
- Bus-error irq: ENABLE=0x2, unmapped access -> cpu_irq=1; write 0x2 to 0x000 with m_pstb=0x1 -> BUSERR clears, cpu_irq=0; same write with m_pstb=0x0 -> no change.
- Simultaneous: clear BUSERR in same cycle as new bus error (slave perr) -> BUSERR remains 1.

Source files
------------

// File: rtl/apb_fabric_intc.sv
// apb_fabric_intc: APB address decoder / return mux for four external slaves
// plus a small interrupt controller (timer level + bus-error latch -> cpu_irq).
module apb_fabric_intc #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rts,
  // CPU master port
  input  logic [ADDR_WIDTH-1:0] m_paddr,
  input  logic [DATA_WIDTH-1:0] m_pwdata,
  output logic [DATA_WIDTH-1:0] m_prdata,
  input  logic                  m_psel,
  input  logic                  m_penable,
  input  logic                  m_pwrite,
  input  logic [3:0]            m_pstb,
  output logic                  m_pready,
  output logic                  m_perr,
  // system ROM
  output logic                  sys_sel,
  output logic                  sys_enable,
  input  logic [DATA_WIDTH-1:0] sys_rdata,
  input  logic                  sys_ready,
  input  logic                  sys_perr,
  // SRAM
  output logic                  sram_sel,
  output logic                  sram_enable,
  input  logic [DATA_WIDTH-1:0] sram_rdata,
  input  logic                  sram_ready,
  input  logic                  sram_perr,
  // UART
  output logic                  uart_sel,
  output logic                  uart_enable,
  input  logic [DATA_WIDTH-1:0] uart_rdata,
  input  logic                  uart_ready,
  input  logic                  uart_perr,
  // timer
  output logic                  timer_sel,
  output logic                  timer_enable,
  input  logic [DATA_WIDTH-1:0] timer_rdata,
  input  logic                  timer_ready,
  input  logic                  timer_perr,
  // interrupts
  input  logic                  timer_irq,
  output logic                  cpu_irq
);

  localparam int unsigned MAP_WIDTH = 32;
  localparam logic [11:0] OFF_PENDING = 12'h000;
  localparam logic [11:0] OFF_ENABLE  = 12'h004;
  localparam logic [11:0] OFF_ACTIVE  = 12'h008;

  logic [MAP_WIDTH-1:0] addr32;
  logic [11:0]          intc_off;
  logic hit_sys, hit_sram, hit_uart, hit_intc, hit_timer;
  logic access;

  logic [1:0] enable_q, enable_d;
  logic       buserr_q, buserr_d;
  logic       cpu_irq_q, cpu_irq_d;
  logic [1:0] pending;
  logic [DATA_WIDTH-1:0] intc_rdata;
  logic intc_wr, buserr_set, buserr_clr;

  logic unused_ok;

  assign addr32   = MAP_WIDTH'(m_paddr);
  assign intc_off = m_paddr[11:0];
  assign access   = m_psel & m_penable;
  assign unused_ok = ^{m_pwdata[DATA_WIDTH-1:2], m_pwdata[0], m_pstb[3:1]};

  // Address decode: at most one region matches any address
  always_comb begin
    hit_sys   = (addr32[31:16] == 16'h0000);
    hit_uart  = (addr32[31:12] == 20'h10000);
    hit_intc  = (addr32[31:12] == 20'h10001);
    hit_timer = (addr32[31:12] == 20'h10002);
    hit_sram  = (addr32[31:28] == 4'h8);
  end

  // Per-slave select / access-phase enable
  always_comb begin
    sys_sel      = m_psel & hit_sys;
    sram_sel     = m_psel & hit_sram;
    uart_sel     = m_psel & hit_uart;
    timer_sel    = m_psel & hit_timer;
    sys_enable   = access & hit_sys;
    sram_enable  = access & hit_sram;
    uart_enable  = access & hit_uart;
    timer_enable = access & hit_timer;
  end

  // Interrupt controller register read view
  always_comb begin
    pending = {buserr_q, timer_irq};
    case (intc_off)
      OFF_PENDING: intc_rdata = DATA_WIDTH'(pending);
      OFF_ENABLE:  intc_rdata = DATA_WIDTH'(enable_q);
      OFF_ACTIVE:  intc_rdata = DATA_WIDTH'(pending & enable_q);
      default:     intc_rdata = '0;
    endcase
  end

  // Return mux: hit slave drives master; INTC is zero-wait; unmapped errors
  always_comb begin
    m_prdata = '0;
    m_pready = 1'b0;
    m_perr   = 1'b0;
    if (m_psel) begin
      if (hit_sys) begin
        m_prdata = sys_rdata;
        m_pready = sys_ready;
        m_perr   = sys_perr;
      end else if (hit_sram) begin
        m_prdata = sram_rdata;
        m_pready = sram_ready;
        m_perr   = sram_perr;
      end else if (hit_uart) begin
        m_prdata = uart_rdata;
        m_pready = uart_ready;
        m_perr   = uart_perr;
      end else if (hit_timer) begin
        m_prdata = timer_rdata;
        m_pready = timer_ready;
        m_perr   = timer_perr;
      end else if (hit_intc) begin
        m_prdata = intc_rdata;
        m_pready = m_penable;
      end else begin
        m_pready = m_penable;
        m_perr   = m_penable;
      end
    end
  end

  // Next-state: register writes, bus-error latch (set beats clear), irq
  always_comb begin
    intc_wr    = access & m_pwrite & hit_intc;
    buserr_set = access & m_pready & m_perr;
    buserr_clr = intc_wr & (intc_off == OFF_PENDING) & m_pstb[0] & m_pwdata[1];
    enable_d   = enable_q;
    if (intc_wr && (intc_off == OFF_ENABLE) && m_pstb[0]) begin
      enable_d = m_pwdata[1:0];
    end
    buserr_d  = buserr_set | (buserr_q & ~buserr_clr);
    cpu_irq_d = |(pending & enable_q);
  end

  // State registers
  always_ff @(posedge clk or posedge rts) begin
    if (rts) begin
      enable_q  <= 2'b00;
      buserr_q  <= 1'b0;
      cpu_irq_q <= 1'b0;
    end else begin
      enable_q  <= enable_d;
      buserr_q  <= buserr_d;
      cpu_irq_q <= cpu_irq_d;
    end
  end

  assign cpu_irq = cpu_irq_q;

endmodule

// File: tb/tb_apb_fabric_intc.sv
// Directed bench for apb_fabric_intc with a per-cycle reference model.
module tb_apb_fabric_intc;

  logic        clk = 1'b0;
  logic        rts;
  logic [31:0] m_paddr, m_pwdata, m_prdata;
  logic        m_psel, m_penable, m_pwrite;
  logic [3:0]  m_pstb;
  logic        m_pready, m_perr;
  logic        sys_sel, sys_enable, sram_sel, sram_enable;
  logic        uart_sel, uart_enable, timer_sel, timer_enable;
  logic [31:0] sys_rdata, sram_rdata, uart_rdata, timer_rdata;
  logic        s_ready, s_perr;
  logic        timer_irq, cpu_irq;

  int checks = 0;
  int failures = 0;

  // model state
  logic [1:0] md_en;
  logic       md_be;
  logic       md_irq;

  always #5 clk = ~clk;

  apb_fabric_intc #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rts(rts),
    .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_prdata(m_prdata),
    .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite), .m_pstb(m_pstb),
    .m_pready(m_pready), .m_perr(m_perr),
    .sys_sel(sys_sel), .sys_enable(sys_enable), .sys_rdata(sys_rdata),
    .sys_ready(s_ready), .sys_perr(s_perr),
    .sram_sel(sram_sel), .sram_enable(sram_enable), .sram_rdata(sram_rdata),
    .sram_ready(s_ready), .sram_perr(s_perr),
    .uart_sel(uart_sel), .uart_enable(uart_enable), .uart_rdata(uart_rdata),
    .uart_ready(s_ready), .uart_perr(s_perr),
    .timer_sel(timer_sel), .timer_enable(timer_enable), .timer_rdata(timer_rdata),
    .timer_ready(s_ready), .timer_perr(s_perr),
    .timer_irq(timer_irq), .cpu_irq(cpu_irq)
  );

  // 0 none, 1 sys, 2 sram, 3 uart, 4 intc, 5 timer
  function automatic int region(input logic [31:0] a);
    if (a <= 32'h0000_FFFF) return 1;
    if (a >= 32'h8000_0000 && a <= 32'h8FFF_FFFF) return 2;
    if (a >= 32'h1000_0000 && a <= 32'h1000_0FFF) return 3;
    if (a >= 32'h1000_1000 && a <= 32'h1000_1FFF) return 4;
    if (a >= 32'h1000_2000 && a <= 32'h1000_2FFF) return 5;
    return 0;
  endfunction

  function automatic logic [31:0] intc_read(input logic [31:0] a);
    int off;
    int pend;
    off  = int'(a - 32'h1000_1000);
    pend = int'(timer_irq) + 2 * int'(md_be);
    if (off == 0) return 32'(pend);
    if (off == 4) return 32'(md_en);
    if (off == 8) return 32'(pend & int'(md_en));
    return 32'h0;
  endfunction

  // expected master-side return values from current inputs and model state
  task automatic expect_ret(output logic [31:0] rd, output logic rdy, output logic er);
    int r;
    r = region(m_paddr);
    rd = 32'h0; rdy = 1'b0; er = 1'b0;
    if (m_psel) begin
      case (r)
        1: begin rd = sys_rdata;   rdy = s_ready; er = s_perr; end
        2: begin rd = sram_rdata;  rdy = s_ready; er = s_perr; end
        3: begin rd = uart_rdata;  rdy = s_ready; er = s_perr; end
        5: begin rd = timer_rdata; rdy = s_ready; er = s_perr; end
        4: begin rd = intc_read(m_paddr); rdy = m_penable; end
        default: begin rdy = m_penable; er = m_penable; end
      endcase
    end
  endtask

  // reference model of the controller state
  always @(posedge clk or posedge rts) begin
    logic [31:0] rd;
    logic rdy, er, irq_n, clr;
    logic [1:0] en_n;
    if (rts) begin
      md_en = 2'b00; md_be = 1'b0; md_irq = 1'b0;
    end else begin
      expect_ret(rd, rdy, er);
      irq_n = (timer_irq && md_en[0]) || (md_be && md_en[1]);
      en_n  = md_en;
      clr   = 1'b0;
      if (m_psel && m_penable && m_pwrite && region(m_paddr) == 4 && m_pstb[0]) begin
        if (m_paddr == 32'h1000_1004) en_n = m_pwdata[1:0];
        if (m_paddr == 32'h1000_1000 && m_pwdata[1]) clr = 1'b1;
      end
      if (m_psel && m_penable && rdy && er) md_be = 1'b1;
      else if (clr) md_be = 1'b0;
      md_en  = en_n;
      md_irq = irq_n;
    end
  end

  // per-cycle comparison of every DUT output against the model
  always @(negedge clk) begin
    logic [31:0] rd;
    logic rdy, er;
    logic [10:0] exp_v, act_v;
    int r;
    expect_ret(rd, rdy, er);
    r = region(m_paddr);
    exp_v = {m_psel && r == 1, m_psel && r == 2, m_psel && r == 3, m_psel && r == 5,
             m_psel && m_penable && r == 1, m_psel && m_penable && r == 2,
             m_psel && m_penable && r == 3, m_psel && m_penable && r == 5,
             rdy, er, md_irq};
    act_v = {sys_sel, sram_sel, uart_sel, timer_sel,
             sys_enable, sram_enable, uart_enable, timer_enable,
             m_pready, m_perr, cpu_irq};
    checks++;
    if (act_v !== exp_v) begin
      failures++;
      $display("FAIL ctrl t=%0t addr=%h got %b want %b", $time, m_paddr, act_v, exp_v);
    end
    checks++;
    if (m_prdata !== rd) begin
      failures++;
      $display("FAIL prdata t=%0t addr=%h got %h want %h", $time, m_paddr, m_prdata, rd);
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // one APB transfer; returns at the negedge of the completing access cycle
  task automatic xfer(input logic [31:0] a, input logic wr, input logic [31:0] wd,
                      input logic [3:0] st, input int waits, input logic serr,
                      output logic [31:0] rd, output logic er, output int nwait);
    int n;
    @(posedge clk); #1;
    m_paddr = a; m_pwrite = wr; m_pwdata = wd; m_pstb = st;
    m_psel = 1'b1; m_penable = 1'b0; s_ready = 1'b0; s_perr = serr;
    @(posedge clk); #1;
    m_penable = 1'b1; n = 0; s_ready = (waits == 0);
    forever begin
      @(negedge clk);
      if (m_pready) break;
      n++;
      if (n > 20) begin
        checks++; failures++;
        $display("FAIL timeout addr=%h got no ready want ready", a);
        break;
      end
      @(posedge clk); #1;
      s_ready = (n >= waits);
    end
    rd = m_prdata; er = m_perr; nwait = n;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    m_psel = 1'b0; m_penable = 1'b0; m_pwrite = 1'b0; s_ready = 1'b0; s_perr = 1'b0;
  endtask

  task automatic rd_chk(input string nm, input logic [31:0] a, input int waits,
                        input logic [31:0] exp_d, input logic exp_e, input int exp_w);
    logic [31:0] rd; logic er; int n;
    xfer(a, 1'b0, 32'h0, 4'h0, waits, 1'b0, rd, er, n);
    check({nm, "_data"}, rd, exp_d);
    check({nm, "_err"}, 32'(er), 32'(exp_e));
    check({nm, "_wait"}, 32'(n), 32'(exp_w));
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st);
    logic [31:0] rd; logic er; int n;
    xfer(a, 1'b1, d, st, 0, 1'b0, rd, er, n);
  endtask

  initial begin
    logic [31:0] rd; logic er; int n;
    rts = 1'b1;
    m_paddr = 32'h0; m_pwdata = 32'h0; m_psel = 1'b0; m_penable = 1'b0;
    m_pwrite = 1'b0; m_pstb = 4'h0; s_ready = 1'b0; s_perr = 1'b0; timer_irq = 1'b0;
    sys_rdata = 32'h0000_C0DE; sram_rdata = 32'hDEAD_BEEF;
    uart_rdata = 32'h0000_00A5; timer_rdata = 32'h1234_5678;
    repeat (2) @(posedge clk);
    #1 rts = 1'b0;
    @(negedge clk);
    check("rst_irq", 32'(cpu_irq), 32'h0);

    // external slaves with wait states passed through
    rd_chk("sram", 32'h8000_0010, 2, 32'hDEAD_BEEF, 1'b0, 2);
    rd_chk("sys",  32'h0000_0004, 1, 32'h0000_C0DE, 1'b0, 1);
    rd_chk("uart", 32'h1000_0000, 0, 32'h0000_00A5, 1'b0, 0);
    rd_chk("tmr",  32'h1000_2000, 3, 32'h1234_5678, 1'b0, 3);
    rd_chk("sysend", 32'h0000_FFFC, 0, 32'h0000_C0DE, 1'b0, 0);

    // unmapped -> error, latches BUSERR
    rd_chk("unmap", 32'h2000_0000, 0, 32'h0, 1'b1, 0);
    rd_chk("pend_be", 32'h1000_1000, 0, 32'h2, 1'b0, 0);
    wr(32'h1000_1000, 32'h2, 4'h1);
    rd_chk("pend_clr", 32'h1000_1000, 0, 32'h0, 1'b0, 0);

    // timer interrupt path
    wr(32'h1000_1004, 32'h1, 4'h1);
    idle();
    timer_irq = 1'b1;
    @(negedge clk);
    check("irq_pre", 32'(cpu_irq), 32'h0);
    @(negedge clk);
    check("irq_tmr", 32'(cpu_irq), 32'h1);
    rd_chk("active", 32'h1000_1008, 0, 32'h1, 1'b0, 0);
    idle();
    timer_irq = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("irq_drop", 32'(cpu_irq), 32'h0);

    // bus-error interrupt path and strobe gating
    wr(32'h1000_1004, 32'hFFFF_FFFE, 4'h1);
    rd_chk("en_rd", 32'h1000_1004, 0, 32'h2, 1'b0, 0);
    wr(32'h1000_1004, 32'h1, 4'h0);
    rd_chk("en_nostb", 32'h1000_1004, 0, 32'h2, 1'b0, 0);
    rd_chk("unmap2", 32'h1000_3000, 0, 32'h0, 1'b1, 0);
    idle(); idle();
    @(negedge clk);
    check("irq_be", 32'(cpu_irq), 32'h1);
    wr(32'h1000_1000, 32'h2, 4'h0);
    idle(); idle();
    rd_chk("be_keep", 32'h1000_1000, 0, 32'h2, 1'b0, 0);
    check("irq_keep", 32'(cpu_irq), 32'h1);
    wr(32'h1000_1000, 32'h2, 4'h1);
    idle(); idle();
    @(negedge clk);
    check("irq_clr", 32'(cpu_irq), 32'h0);

    // slave error right behind a clear: error must leave BUSERR set
    wr(32'h1000_1000, 32'h2, 4'h1);
    xfer(32'h8000_0000, 1'b0, 32'h0, 4'h0, 0, 1'b1, rd, er, n);
    check("sram_err", 32'(er), 32'h1);
    rd_chk("be_slv", 32'h1000_1000, 0, 32'h2, 1'b0, 0);

    // reserved offset and out-of-range boundaries
    wr(32'h1000_100C, 32'hFFFF_FFFF, 4'hF);
    rd_chk("resv", 32'h1000_100C, 0, 32'h0, 1'b0, 0);
    rd_chk("sys_over", 32'h0001_0000, 0, 32'h0, 1'b1, 0);
    rd_chk("sram_over", 32'h9000_0000, 0, 32'h0, 1'b1, 0);

    // reset in the middle of an access
    wr(32'h1000_1004, 32'h3, 4'h1);
    timer_irq = 1'b1;
    @(posedge clk); #1;
    m_paddr = 32'h8000_0020; m_pwrite = 1'b0; m_psel = 1'b1; m_penable = 1'b0;
    s_ready = 1'b0;
    @(posedge clk); #1;
    m_penable = 1'b1;
    #3 rts = 1'b1;
    @(negedge clk);
    check("rst_mid_irq", 32'(cpu_irq), 32'h0);
    check("rst_mid_sel", 32'(sram_enable), 32'h1);
    repeat (2) @(posedge clk);
    #1 rts = 1'b0; m_psel = 1'b0; m_penable = 1'b0; timer_irq = 1'b0;
    rd_chk("rst_en", 32'h1000_1004, 0, 32'h0, 1'b0, 0);
    rd_chk("rst_pend", 32'h1000_1000, 0, 32'h0, 1'b0, 0);
    idle();
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
